// File: rtl/usr_shift_ctrl.sv
// usr_shift_ctrl: sequences one parallel load then N shifts into a 4-bit USR.
// All outputs registered; done pulses for one cycle when the job completes.
module usr_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_count,
    input  logic             req_fill,
    input  logic             abort,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] b,
    output logic             serial_in_lshft,
    output logic             serial_in_rshft,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_MSB  = 2'b01;
    localparam logic [1:0] SEL_LSB  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    state_t           state;
    logic             dir_q;
    logic             fill_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] remaining;

    // Job FSM; every USR control line is a register so the USR sees clean edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            sel             <= SEL_HOLD;
            b               <= '0;
            serial_in_lshft <= 1'b0;
            serial_in_rshft <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            req_ready       <= 1'b0;
            dir_q           <= 1'b0;
            fill_q          <= 1'b0;
            count_q         <= '0;
            remaining       <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                // cancel wins over the normal step; USR just holds
                state           <= IDLE;
                sel             <= SEL_HOLD;
                serial_in_lshft <= 1'b0;
                serial_in_rshft <= 1'b0;
                busy            <= 1'b0;
                req_ready       <= 1'b1;
                remaining       <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        req_ready <= 1'b1;
                        if (req_valid && req_ready) begin
                            dir_q     <= req_dir;
                            fill_q    <= req_fill;
                            count_q   <= req_count;
                            b         <= req_data;
                            sel       <= SEL_LOAD;
                            state     <= LOAD;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (count_q == '0) begin
                            sel   <= SEL_HOLD;
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            sel             <= dir_q ? SEL_LSB : SEL_MSB;
                            serial_in_lshft <= dir_q ? 1'b0 : fill_q;
                            serial_in_rshft <= dir_q ? fill_q : 1'b0;
                            remaining       <= count_q;
                            state           <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        remaining <= remaining - 1'b1;
                        if (remaining == 1) begin
                            sel             <= SEL_HOLD;
                            serial_in_lshft <= 1'b0;
                            serial_in_rshft <= 1'b0;
                            state           <= DONE;
                            done            <= 1'b1;
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// tb_usr_shift_ctrl: drives directed jobs into usr_shift_ctrl with a USR model.
// A queue holds expected results; a monitor pops and checks on each done.
module tb_usr_shift_ctrl;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  req_data = '0;
    logic          req_dir = 1'b0;
    logic [CW-1:0] req_count = '0;
    logic          req_fill = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    sel;
    logic [W-1:0]  b;
    logic          serial_in_lshft;
    logic          serial_in_rshft;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    usr_shift_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data(req_data),
        .req_dir(req_dir),
        .req_count(req_count),
        .req_fill(req_fill),
        .abort(abort),
        .sel(sel),
        .b(b),
        .serial_in_lshft(serial_in_lshft),
        .serial_in_rshft(serial_in_rshft),
        .busy(busy),
        .done(done)
    );

    typedef struct {
        logic [W-1:0] q;
        int           lat;
        int           shifts;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    int           nerr = 0;
    int           nchk = 0;
    logic [W-1:0] usr_q = '0;
    logic [W-1:0] q_snap = '0;
    logic [1:0]   sel_s = 2'b11;
    logic [W-1:0] b_s = '0;
    logic         sl_s = 1'b0;
    logic         sr_s = 1'b0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           nshift = 0;
    int           nload = 0;
    logic         prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // USR model: acts on controls sampled mid-cycle, so no edge race
    initial forever begin
        @(posedge clk);
        case (sel_s)
            2'b00: usr_q = b_s;
            2'b01: usr_q = {usr_q[W-2:0], sl_s};
            2'b10: usr_q = {sr_s, usr_q[W-1:1]};
            default: usr_q = usr_q;
        endcase
    end

    // monitor: samples on the falling edge, pops expectations on done
    initial forever begin
        @(negedge clk);
        cyc++;
        sel_s = sel;
        b_s   = b;
        sl_s  = serial_in_lshft;
        sr_s  = serial_in_rshft;
        if (rst) begin
            if (sel == 2'b00) nload++;
            if (sel == 2'b01 || sel == 2'b10) nshift++;
            if (done) begin
                if (sbq.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_done: got done=1 want no job pending");
                end else begin
                    mon_e = sbq.pop_front();
                    check("usr_q", 32'(usr_q), 32'(mon_e.q));
                    check("latency", cyc - acc_cyc, mon_e.lat);
                    check("shift_cycles", nshift, mon_e.shifts);
                    check("load_cycles", nload, 1);
                    check("done_one_cycle", 32'(prev_done), 0);
                    check("busy_at_done", 32'(busy), 1);
                end
            end
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                nshift  = 0;
                nload   = 0;
            end
        end
        prev_done = done;
    end

    // present a job at posedge+1 and hold it until the accept edge
    task automatic send(input logic [W-1:0] d, input logic dr,
                        input logic [CW-1:0] c, input logic f,
                        input logic [W-1:0] eq, input bit track,
                        input bit keep);
        exp_t e;
        int   t;
        req_data  = d;
        req_dir   = dr;
        req_count = c;
        req_fill  = f;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!req_ready) begin
            nchk++;
            nerr++;
            $display("FAIL accept_timeout: req_ready=0 want 1");
        end else if (track) begin
            e.q      = eq;
            e.lat    = int'(c) + 2;
            e.shifts = int'(c);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain", sbq.size(), 0);
    endtask

    initial begin
        #1 rst = 1'b0;
        #12;
        check("rst_sel", 32'(sel), 3);
        check("rst_b", 32'(b), 0);
        check("rst_lshft", 32'(serial_in_lshft), 0);
        check("rst_rshft", 32'(serial_in_rshft), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(req_ready), 1);

        send(4'b1011, 1'b0, 3'd2, 1'b0, 4'b1100, 1'b1, 1'b0);
        send(4'b1011, 1'b1, 3'd1, 1'b1, 4'b1101, 1'b1, 1'b0);
        send(4'b0110, 1'b0, 3'd0, 1'b1, 4'b0110, 1'b1, 1'b0);
        send(4'b0000, 1'b0, 3'd7, 1'b1, 4'b1111, 1'b1, 1'b1);
        send(4'b1001, 1'b1, 3'd3, 1'b0, 4'b0001, 1'b1, 1'b0);
        send(4'b1010, 1'b1, 3'd6, 1'b1, 4'b1111, 1'b1, 1'b0);
        drain();

        // asynchronous reset in the middle of a shift run
        send(4'b1010, 1'b0, 3'd7, 1'b1, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_shift_sel", 32'(sel), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_sel", 32'(sel), 3);
        check("arst_b", 32'(b), 0);
        check("arst_lshft", 32'(serial_in_lshft), 0);
        check("arst_rshft", 32'(serial_in_rshft), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        q_snap = usr_q;
        repeat (3) @(posedge clk);
        #1;
        check("usr_frozen", 32'(usr_q), 32'(q_snap));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_arst", 32'(req_ready), 1);

        // abort in the second shift cycle with the next job held on valid
        send(4'b0011, 1'b0, 3'd5, 1'b0, 4'b0000, 1'b0, 1'b1);
        req_data  = 4'b0101;
        req_dir   = 1'b1;
        req_count = 3'd2;
        req_fill  = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_sel", 32'(sel), 3);
        check("abort_done", 32'(done), 0);
        check("abort_ready", 32'(req_ready), 1);
        check("abort_busy", 32'(busy), 0);
        mon_e.q      = 4'b0001;
        mon_e.lat    = 4;
        mon_e.shifts = 2;
        sbq.push_back(mon_e);
        @(posedge clk);
        #1;
        check("reaccept_sel", 32'(sel), 0);
        check("reaccept_b", 32'(b), 32'h5);
        req_valid = 1'b0;
        drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/usr_shift_ctrl.md
Name: usr_shift_ctrl

Overview:
- Sequencing controller that sits directly upstream of the team's 4-bit universal shift register (USR).
- Accepts a job over a valid/ready handshake: a parallel word, a shift direction, a shift count and a fill bit.
- Drives the USR mode select, parallel-load bus and serial inputs so the USR does one parallel load, then exactly N shifts, then holds.
- Signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 4, width of the USR datapath and of req_data/b.
- CNT_W, 3, width of req_count; the maximum shift count is 2^CNT_W-1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  job request valid.
- req_ready  output  1  controller can accept a job.
- req_data  input  WIDTH  word to parallel-load into the USR.
- req_dir  input  1  0 = shift toward MSB, 1 = shift toward LSB.
- req_count  input  CNT_W  number of shift cycles after the load.
- req_fill  input  1  bit shifted in at the vacated end.
- abort  input  1  synchronous cancel of the current job.
- sel  output  2  USR mode: 00 load, 01 shift toward MSB, 10 shift toward LSB, 11 hold.
- b  output  WIDTH  USR parallel-load bus.
- serial_in_lshft  output  1  USR LSB serial input, used in mode 01.
- serial_in_rshft  output  1  USR MSB serial input, used in mode 10.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered. Clock is clk only.
- Reset (rst low, async): state=IDLE, sel=11, b=0, both serial inputs=0, busy=0, done=0, internal counter=0. req_ready goes high in IDLE once reset is released.
- Reset asserted mid-job returns immediately to these values. The USR is left holding whatever it had captured.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - req_ready=1, sel=11.
  - Accept on the edge where req_valid&&req_ready. On that edge, capture dir/count/fill, drive b<=req_data, sel<=00, move to LOAD.
- LOAD (one cycle; the USR samples sel=00 at the next edge):
  - If count==0: go to DONE with sel<=11.
  - Else: go to SHIFT with sel<=(dir?10:01), the serial input on the vacated end <=fill, the other serial input <=0, remaining<=count.
- SHIFT:
  - Each edge decrements remaining.
  - On the edge where remaining==1: sel<=11, go to DONE.
  - Exactly count shift cycles are presented to the USR.
- DONE: done=1 for exactly one cycle, sel=11, then return to IDLE.
- req_ready=0 in LOAD, SHIFT and DONE. A req_valid held through a job is accepted on the first IDLE cycle after DONE.
- Job latency: accept edge → LOAD → count SHIFT cycles → DONE, i.e. done is high count+2 cycles after the accept cycle.
- b stays stable at the captured req_data from LOAD until the next accept. Changes to req_* after accept are ignored.
- abort:
  - Sampled in LOAD, SHIFT and DONE. If high at an edge: state<=IDLE, sel<=11, no done pulse.
  - Ignored in IDLE. Abort has priority over the normal transition on the same edge.
- count may exceed WIDTH; the USR then ends with every bit equal to fill.
- sel is never 01 or 10 outside SHIFT, and never 00 outside LOAD.

Test Plan:
- Reset mid-SHIFT (rst low asynchronously) → outputs return to reset values within the same cycle without waiting for a clock edge; req_ready is high after release; USR contents are frozen.
- data=1011, dir=0, count=2, fill=0 with the USR attached → sel sequence 00,01,01,11; USR q=1100; done high 4 cycles after the accept.
- data=1011, dir=1, count=1, fill=1 → sel 00,10,11; serial_in_rshft=1; q=1101; one done pulse.
- count=0, data=0110 → sel 00 then 11; q=0110; done 2 cycles after the accept; SHIFT never entered.
- count=7, dir=0, fill=1, data=0000 → q=1111; exactly 7 cycles with sel=01.
- abort asserted in the 2nd SHIFT cycle of a count=5 job → sel=11 on the next cycle, no done, req_ready=1. A back-to-back req_valid held throughout is accepted the cycle after the abort returns to IDLE.
